dot_prod_stream: RTL and testbench
==================================

Name: dot_prod_stream

Overview:
- Streaming complex dot product. Accepts one (x, y) complex sample pair per handshake and accumulates LENGTH products.
- Emits one i/q sum per frame of LENGTH samples on a valid/ready output.
- Successor to the parallel-vector dot product: serial input, parametric length, optional conjugation of y, full backpressure and a synchronous frame clear.
- Sits between the sample buffers and the CAF peak search.

Parameters:
- XI_BITS, 8, signed width of xi
- XQ_BITS, 8, signed width of xq
- YI_BITS, 8, signed width of yi
- YQ_BITS, 8, signed width of yq
- LENGTH, 4, samples per dot product; must be >= 2
- CONJ, 1, 1 computes sum x*conj(y); 0 computes sum x*y

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- clear  in  1  synchronous frame restart
- s_axis_x_tvalid  in  1  x sample valid
- s_axis_x_tready  out  1  x ready
- xi  in  XI_BITS  x real, signed
- xq  in  XQ_BITS  x imaginary, signed
- s_axis_y_tvalid  in  1  y sample valid
- s_axis_y_tready  out  1  y ready; identical to s_axis_x_tready
- yi  in  YI_BITS  y real, signed
- yq  in  YQ_BITS  y imaginary, signed
- m_axis_product_tvalid  out  1  result valid
- m_axis_product_tready  in  1  downstream ready
- i  out  SUM_I_SIZE  real sum, signed
- q  out  SUM_Q_SIZE  imaginary sum, signed

Behaviour:
- Reset (async assert, sync release):
  - m_axis_product_tvalid=0, i=0, q=0.
  - Accumulators, sample counter and all pipeline valid bits cleared.
  - Both treadys are 0 while reset is asserted.
- Stall: stall = m_axis_product_tvalid & ~m_axis_product_tready. All pipeline stages hold while stall=1.
- Ready: s_axis_*_tready = ~stall & ~clear. Ready never depends on tvalid.
- Accept: a sample is accepted on an edge where ready=1 and both x and y tvalid are 1. If only one tvalid is high, nothing is consumed.
- Arithmetic: signed two's complement, all operands sign-extended.
  - PROD_BITS = max(XI+YI, XQ+YQ, XI+YQ, XQ+YI).
  - SUM_I_SIZE = SUM_Q_SIZE = PROD_BITS + 1 + clog2(LENGTH). Overflow is impossible by construction.
  - CONJ=1: pi = xi*yi + xq*yq; pq = xq*yi - xi*yq.
  - CONJ=0: pi = xi*yi - xq*yq; pq = xi*yq + xq*yi.
- Pipeline: edge k accepts the sample into stage A, edge k+1 forms the four products (stage B), edge k+2 forms pi/pq (stage C), edge k+3 updates the accumulator.
- Frame counter: counts C-stage products 0..LENGTH-1.
  - At count LENGTH-1, the output register loads acc+C, the accumulator reloads 0, and the counter wraps to 0.
  - Otherwise acc <= acc + C.
- Latency: the last sample of a frame accepted at edge k gives m_axis_product_tvalid=1 after edge k+3 with no stall. Back-to-back frames sustain 1 sample/cycle.
- Output: i, q and tvalid hold stable until a tvalid & tready edge. On that edge tvalid drops unless a new result loads on the same edge, in which case tvalid stays 1 with the new data.
- clear (synchronous):
  - Zeroes the accumulator and counter and drops A/B/C valid bits, flushing in-flight samples.
  - A pending output result is kept.
  - Samples are not accepted during clear, because ready=0.
- reset mid-frame discards all partial state and any pending output.

Decomposition:
- Package dot_prod_pkg: PROD_BITS and SUM size computation functions, plus a max() helper.
- One sub-module, complex_mult_pipe: stages A–C with valid and enable, and the CONJ select.
- The top module holds the counter, accumulator, output register and stall logic.

Test Plan:
- Reset: assert reset mid-stream -> tvalid=0, i=q=0, treadys=0 immediately; after release the first output needs 4 fresh samples.
- CONJ=1, LENGTH=4: four samples x=(1,2), y=(3,4) accepted on consecutive edges, tready=1 -> i=44, q=8, tvalid after 3rd edge past last accept, one cycle.
- CONJ=0: same stimulus -> i=-20, q=40; extremes x=y=(-128,-128) ×4 -> i=0, q=131072, no overflow at 19 bits.
- Backpressure: 8 samples streamed with m_axis_product_tready=0 -> first result held stable, treadys fall, no sample lost; on tready=1 -> frame1 then frame2 delivered in order.
- Handshake gaps: x valid with y invalid for 3 cycles -> nothing consumed; sums equal the gap-free run.
- Clear: 2 samples, pulse clear, then 4 samples of x=(1,0), y=(1,0) -> single result i=4, q=0; earlier samples excluded.

Source files
------------

// File: rtl/dot_prod_pkg.sv
// Width helpers for the streaming complex dot product.
// Product and sum widths are derived so the accumulator can never overflow.
package dot_prod_pkg;

  function automatic int max2(input int a, input int b);
    int r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  function automatic int prod_bits(input int xi_bits, input int xq_bits,
                                   input int yi_bits, input int yq_bits);
    return max2(max2(xi_bits + yi_bits, xq_bits + yq_bits),
                max2(xi_bits + yq_bits, xq_bits + yi_bits));
  endfunction

  // One extra bit for the pi/pq add, clog2(length) bits for the frame sum.
  function automatic int sum_size(input int p_bits, input int length);
    return p_bits + 1 + $clog2(length);
  endfunction

endpackage

// File: rtl/complex_mult_pipe.sv
// Three-stage complex multiplier: A captures operands, B forms the four
// partial products, C combines them into pi/pq with optional conjugation of y.
module complex_mult_pipe
  import dot_prod_pkg::*;
#(
  parameter int XI_BITS = 8,
  parameter int XQ_BITS = 8,
  parameter int YI_BITS = 8,
  parameter int YQ_BITS = 8,
  parameter int CONJ    = 1,
  localparam int PROD_BITS = prod_bits(XI_BITS, XQ_BITS, YI_BITS, YQ_BITS),
  localparam int PC_BITS   = PROD_BITS + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic signed [XI_BITS-1:0] xi,
  input  logic signed [XQ_BITS-1:0] xq,
  input  logic signed [YI_BITS-1:0] yi,
  input  logic signed [YQ_BITS-1:0] yq,
  output logic                      out_valid,
  output logic signed [PC_BITS-1:0] pi,
  output logic signed [PC_BITS-1:0] pq
);

  logic signed [XI_BITS-1:0]   xi_r;
  logic signed [XQ_BITS-1:0]   xq_r;
  logic signed [YI_BITS-1:0]   yi_r;
  logic signed [YQ_BITS-1:0]   yq_r;
  logic                        a_valid_r;
  logic                        b_valid_r;
  logic signed [PROD_BITS-1:0] xi_e_s, xq_e_s, yi_e_s, yq_e_s;
  logic signed [PROD_BITS-1:0] p_ii_r, p_qq_r, p_iq_r, p_qi_r;
  logic signed [PC_BITS-1:0]   pi_s, pq_s;

  // Operands are sign-extended to the full product width before multiplying.
  assign xi_e_s = PROD_BITS'(xi_r);
  assign xq_e_s = PROD_BITS'(xq_r);
  assign yi_e_s = PROD_BITS'(yi_r);
  assign yq_e_s = PROD_BITS'(yq_r);

  // Stage C combine: conjugating y flips the sign of the yq terms.
  always_comb begin
    pi_s = '0;
    pq_s = '0;
    if (CONJ != 0) begin
      pi_s = PC_BITS'(p_ii_r) + PC_BITS'(p_qq_r);
      pq_s = PC_BITS'(p_qi_r) - PC_BITS'(p_iq_r);
    end else begin
      pi_s = PC_BITS'(p_ii_r) - PC_BITS'(p_qq_r);
      pq_s = PC_BITS'(p_iq_r) + PC_BITS'(p_qi_r);
    end
  end

  // Valid bits: clear flushes every in-flight sample regardless of stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      a_valid_r <= in_valid;
      b_valid_r <= a_valid_r;
      out_valid <= b_valid_r;
    end
  end

  // Datapath registers advance together whenever the pipe is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xi_r   <= '0;
      xq_r   <= '0;
      yi_r   <= '0;
      yq_r   <= '0;
      p_ii_r <= '0;
      p_qq_r <= '0;
      p_iq_r <= '0;
      p_qi_r <= '0;
      pi     <= '0;
      pq     <= '0;
    end else if (en) begin
      xi_r   <= xi;
      xq_r   <= xq;
      yi_r   <= yi;
      yq_r   <= yq;
      p_ii_r <= xi_e_s * yi_e_s;
      p_qq_r <= xq_e_s * yq_e_s;
      p_iq_r <= xi_e_s * yq_e_s;
      p_qi_r <= xq_e_s * yi_e_s;
      pi     <= pi_s;
      pq     <= pq_s;
    end
  end

endmodule

// File: rtl/dot_prod_stream.sv
// Streaming complex dot product: accumulates LENGTH products per frame and
// presents one i/q sum on a valid/ready output with full backpressure.
module dot_prod_stream
  import dot_prod_pkg::*;
#(
  parameter int XI_BITS = 8,
  parameter int XQ_BITS = 8,
  parameter int YI_BITS = 8,
  parameter int YQ_BITS = 8,
  parameter int LENGTH  = 4,
  parameter int CONJ    = 1,
  localparam int PROD_BITS  = prod_bits(XI_BITS, XQ_BITS, YI_BITS, YQ_BITS),
  localparam int PC_BITS    = PROD_BITS + 1,
  localparam int SUM_I_SIZE = sum_size(PROD_BITS, LENGTH),
  localparam int SUM_Q_SIZE = sum_size(PROD_BITS, LENGTH),
  localparam int CNT_BITS   = $clog2(LENGTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         s_axis_x_tvalid,
  output logic                         s_axis_x_tready,
  input  logic signed [XI_BITS-1:0]    xi,
  input  logic signed [XQ_BITS-1:0]    xq,
  input  logic                         s_axis_y_tvalid,
  output logic                         s_axis_y_tready,
  input  logic signed [YI_BITS-1:0]    yi,
  input  logic signed [YQ_BITS-1:0]    yq,
  output logic                         m_axis_product_tvalid,
  input  logic                         m_axis_product_tready,
  output logic signed [SUM_I_SIZE-1:0] i,
  output logic signed [SUM_Q_SIZE-1:0] q
);

  logic                         stall_s, ready_s, accept_s, en_s;
  logic                         c_valid_s, last_s, step_s, load_s;
  logic signed [PC_BITS-1:0]    c_pi_s, c_pq_s;
  logic signed [SUM_I_SIZE-1:0] acc_i_r, sum_i_s;
  logic signed [SUM_Q_SIZE-1:0] acc_q_r, sum_q_s;
  logic [CNT_BITS-1:0]          cnt_r;

  // Ready is held low throughout reset and never looks at tvalid.
  assign stall_s         = m_axis_product_tvalid & ~m_axis_product_tready;
  assign ready_s         = ~stall_s & ~clear & ~reset;
  assign s_axis_x_tready = ready_s;
  assign s_axis_y_tready = ready_s;
  assign accept_s        = ready_s & s_axis_x_tvalid & s_axis_y_tvalid;
  assign en_s            = ~stall_s;

  assign last_s  = (cnt_r == CNT_BITS'(LENGTH - 1));
  assign step_s  = en_s & c_valid_s & ~clear;
  assign load_s  = step_s & last_s;
  assign sum_i_s = acc_i_r + SUM_I_SIZE'(c_pi_s);
  assign sum_q_s = acc_q_r + SUM_Q_SIZE'(c_pq_s);

  complex_mult_pipe #(
    .XI_BITS (XI_BITS),
    .XQ_BITS (XQ_BITS),
    .YI_BITS (YI_BITS),
    .YQ_BITS (YQ_BITS),
    .CONJ    (CONJ)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .en        (en_s),
    .in_valid  (accept_s),
    .xi        (xi),
    .xq        (xq),
    .yi        (yi),
    .yq        (yq),
    .out_valid (c_valid_s),
    .pi        (c_pi_s),
    .pq        (c_pq_s)
  );

  // Frame accumulator and product counter; the last product of a frame
  // goes straight to the output register and restarts the sum at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i_r <= '0;
      acc_q_r <= '0;
      cnt_r   <= '0;
    end else if (clear) begin
      acc_i_r <= '0;
      acc_q_r <= '0;
      cnt_r   <= '0;
    end else if (step_s) begin
      if (last_s) begin
        acc_i_r <= '0;
        acc_q_r <= '0;
        cnt_r   <= '0;
      end else begin
        acc_i_r <= sum_i_s;
        acc_q_r <= sum_q_s;
        cnt_r   <= cnt_r + CNT_BITS'(1'b1);
      end
    end
  end

  // Output register: a new result may replace one leaving on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_product_tvalid <= 1'b0;
      i                     <= '0;
      q                     <= '0;
    end else if (load_s) begin
      m_axis_product_tvalid <= 1'b1;
      i                     <= sum_i_s;
      q                     <= sum_q_s;
    end else if (m_axis_product_tvalid && m_axis_product_tready) begin
      m_axis_product_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_prod_stream.sv
// Bench for dot_prod_stream: two instances (CONJ=1 and CONJ=0) share one
// stimulus stream and are scored against a frame-level arithmetic model.
module tb_dot_prod_stream;

  localparam int LEN = 4;
  localparam int SW  = 19;

  logic clk = 1'b0;
  logic reset, clear, xv, yv, tready, rand_rdy;
  logic signed [7:0] xi, xq, yi, yq;
  logic rdy_x1, rdy_y1, rdy_x0, rdy_y0, v1, v0;
  logic signed [SW-1:0] i1, q1, i0, q0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dot_prod_stream #(.LENGTH(LEN), .CONJ(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear),
    .s_axis_x_tvalid(xv), .s_axis_x_tready(rdy_x1), .xi(xi), .xq(xq),
    .s_axis_y_tvalid(yv), .s_axis_y_tready(rdy_y1), .yi(yi), .yq(yq),
    .m_axis_product_tvalid(v1), .m_axis_product_tready(tready),
    .i(i1), .q(q1)
  );

  dot_prod_stream #(.LENGTH(LEN), .CONJ(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear),
    .s_axis_x_tvalid(xv), .s_axis_x_tready(rdy_x0), .xi(xi), .xq(xq),
    .s_axis_y_tvalid(yv), .s_axis_y_tready(rdy_y0), .yi(yi), .yq(yq),
    .m_axis_product_tvalid(v0), .m_axis_product_tready(tready),
    .i(i0), .q(q0)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame-level model: plain complex arithmetic per accepted sample pair.
  longint a_i1, a_q1, a_i0, a_q0;
  int n_part;
  longint e_i1[$], e_q1[$], e_i0[$], e_q0[$];
  logic hold1, hold0;
  logic signed [SW-1:0] hi1, hq1, hi0, hq0;

  always @(negedge clk) begin : monitor
    logic exp_rdy;
    longint ar, ai, br, bi;
    exp_rdy = !reset && !clear && !(v1 && !tready);
    check("ready", {rdy_x1, rdy_y1, rdy_x0, rdy_y0}, {4{exp_rdy}});
    if (reset) begin
      n_part = 0; a_i1 = 0; a_q1 = 0; a_i0 = 0; a_q0 = 0;
      e_i1.delete(); e_q1.delete(); e_i0.delete(); e_q0.delete();
      hold1 = 1'b0; hold0 = 1'b0;
    end else begin
      if (hold1) check("hold1", {v1, i1, q1}, {1'b1, hi1, hq1});
      if (hold0) check("hold0", {v0, i0, q0}, {1'b1, hi0, hq0});
      hold1 = v1 && !tready; hi1 = i1; hq1 = q1;
      hold0 = v0 && !tready; hi0 = i0; hq0 = q0;
      if (v1 && tready) begin
        if (e_i1.size() == 0) check("spurious1", 1, 0);
        else begin
          check("sum_i1", i1, e_i1.pop_front());
          check("sum_q1", q1, e_q1.pop_front());
        end
      end
      if (v0 && tready) begin
        if (e_i0.size() == 0) check("spurious0", 1, 0);
        else begin
          check("sum_i0", i0, e_i0.pop_front());
          check("sum_q0", q0, e_q0.pop_front());
        end
      end
      if (clear) begin
        n_part = 0; a_i1 = 0; a_q1 = 0; a_i0 = 0; a_q0 = 0;
      end else if (exp_rdy && xv && yv) begin
        ar = xi; ai = xq; br = yi; bi = yq;
        a_i1 += ar * br + ai * bi;
        a_q1 += ai * br - ar * bi;
        a_i0 += ar * br - ai * bi;
        a_q0 += ar * bi + ai * br;
        n_part++;
        if (n_part == LEN) begin
          e_i1.push_back(a_i1); e_q1.push_back(a_q1);
          e_i0.push_back(a_i0); e_q0.push_back(a_q0);
          n_part = 0; a_i1 = 0; a_q1 = 0; a_i0 = 0; a_q0 = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) tready = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  // Presents one sample; x alone is valid for 'gap' cycles first.
  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b,
                      input logic signed [7:0] c, input logic signed [7:0] d,
                      input int gap);
    logic ok;
    xi = a; xq = b; yi = c; yq = d;
    xv = 1'b1; yv = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    yv = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      ok = rdy_x1;
      tick();
    end
    xv = 1'b0; yv = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send_rand(input int gap);
    send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), gap);
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (!v1 && t < 30) begin
      tick();
      t++;
    end
    if (!v1) check(tag, 0, 1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; xv = 1'b0; yv = 1'b0; tready = 1'b1;
    rand_rdy = 1'b0; xi = '0; xq = '0; yi = '0; yq = '0;
    tick(); tick();
    check("rst_out", {v1, i1, q1, v0}, 0);
    check("rst_rdy", {rdy_x1, rdy_y1, rdy_x0, rdy_y0}, 0);
    reset = 1'b0;
    tick();

    // Reference frame on consecutive edges, with exact latency.
    for (int n = 0; n < 4; n++) send(8'sd1, 8'sd2, 8'sd3, 8'sd4, 0);
    for (int e = 0; e < 3; e++) begin
      check("lat_early", v1, 0);
      tick();
    end
    check("lat_valid", {v1, v0}, 2'b11);
    check("ex_i1", i1, 44);
    check("ex_q1", q1, 8);
    check("ex_i0", i0, -20);
    check("ex_q0", q0, 40);
    tick();
    check("one_cycle", {v1, v0}, 2'b00);

    // Most negative operands: largest magnitude sums.
    for (int n = 0; n < 4; n++) send(8'sh80, 8'sh80, 8'sh80, 8'sh80, 0);
    wait_valid("ext_timeout");
    check("ext_i1", i1, 131072);
    check("ext_q1", q1, 0);
    check("ext_i0", i0, 0);
    check("ext_q0", q0, 131072);
    tick();

    // x valid alone for 3 cycles per sample consumes nothing extra.
    for (int n = 0; n < 4; n++) send(8'sd1, 8'sd2, 8'sd3, 8'sd4, 3);
    wait_valid("gap_timeout");
    check("gap_i1", i1, 44);
    check("gap_q1", q1, 8);
    check("gap_i0", i0, -20);
    check("gap_q0", q0, 40);
    tick();

    // Backpressure: 8 samples while downstream holds off.
    tready = 1'b0;
    fork
      begin
        for (int n = 0; n < 8; n++) send_rand(0);
      end
      begin
        repeat (15) tick();
        check("bp_stall", {v1, rdy_x1}, 2'b10);
        tready = 1'b1;
      end
    join
    repeat (8) tick();

    // Random stream with random downstream readiness.
    rand_rdy = 1'b1;
    for (int n = 0; n < 48; n++) begin
      send_rand($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) tick();
    end
    rand_rdy = 1'b0;
    tready = 1'b1;
    repeat (10) tick();

    // Clear discards the partial frame already in the accumulator.
    send_rand(0);
    send_rand(0);
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int n = 0; n < 4; n++) send(8'sd1, 8'sd0, 8'sd1, 8'sd0, 0);
    wait_valid("clr_timeout");
    check("clr_i1", i1, 4);
    check("clr_q1", q1, 0);
    check("clr_i0", i0, 4);
    check("clr_q0", q0, 0);
    tick();

    // Reset with a pending result and a partial frame in flight.
    tready = 1'b0;
    for (int n = 0; n < 6; n++) send_rand(0);
    repeat (3) tick();
    check("pre_rst_valid", v1, 1);
    reset = 1'b1;
    #1;
    check("rst_async_out", {v1, i1, q1, v0, i0, q0}, 0);
    check("rst_async_rdy", {rdy_x1, rdy_y1, rdy_x0, rdy_y0}, 0);
    tick();
    reset = 1'b0;
    tready = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) send(8'sd1, 8'sd1, 8'sd1, 8'sd1, 0);
    repeat (6) tick();
    check("rst_fresh", {v1, v0}, 2'b00);
    send(8'sd1, 8'sd1, 8'sd1, 8'sd1, 0);
    wait_valid("fresh_timeout");
    check("fresh_i1", i1, 8);
    check("fresh_q1", q1, 0);
    check("fresh_i0", i0, 0);
    check("fresh_q0", q0, 8);

    repeat (10) tick();
    check("undelivered", e_i1.size() + e_i0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
